// File: rtl/systolic_pkg.sv
// Shared types and defaults for the 2x2 systolic array front end.
package systolic_pkg;

  localparam int BITWIDTH = 4;
  localparam int FIFO_DEPTH_DEFAULT = 4;
  localparam int DRAIN_CYCLES_DEFAULT = 3;

  typedef enum logic [1:0] {IDLE, W1, STREAM, DRAIN} feeder_state_t;

  typedef struct packed {
    logic                last;
    logic [BITWIDTH-1:0] data;
  } act_entry_t;

endpackage

// File: rtl/systolic_feeder_2x2_fifo.sv
// Activation buffer: synchronous FIFO, async reset, registered storage (no pass-through).
module feeder_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;

  a_no_push_full: assert property (@(posedge clk) disable iff (reset) !(push && full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (reset) !(pop && empty));

endmodule

// File: rtl/systolic_feeder_2x2.sv
// Sequencer for the 2x2 systolic core: two weight preload beats, activation stream, zero drain.
module systolic_feeder_2x2
  import systolic_pkg::*;
#(
  parameter int BITWIDTH     = systolic_pkg::BITWIDTH,
  parameter int DEPTH        = systolic_pkg::FIFO_DEPTH_DEFAULT,
  parameter int DRAIN_CYCLES = systolic_pkg::DRAIN_CYCLES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [2*BITWIDTH-1:0] w_data,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [BITWIDTH-1:0]   a_data,
  input  logic                  a_last,
  output logic                  preload_en,
  output logic [BITWIDTH-1:0]   din0,
  output logic [BITWIDTH-1:0]   din1,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  // Handshakes: a beat transfers on a rising edge where valid && ready are both high;
  // ready depends only on FSM state and FIFO fill, never on the matching valid.

  feeder_state_t         state_q, state_d;
  logic                  preload_q, preload_d;
  logic [BITWIDTH-1:0]   din0_q, din0_d;
  logic [BITWIDTH-1:0]   din1_q, din1_d;
  logic                  done_q, done_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  fifo_push, fifo_pop;
  logic [BITWIDTH:0]     fifo_rd;
  logic                  fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                  pop_last;
  logic [BITWIDTH-1:0]   pop_data;

  assign w_ready   = (state_q == IDLE) || (state_q == W1);
  assign a_ready   = !fifo_full;
  assign busy      = (state_q != IDLE);
  assign fifo_push = a_valid && a_ready;
  assign pop_last  = fifo_rd[BITWIDTH];
  assign pop_data  = fifo_rd[BITWIDTH-1:0];

  feeder_fifo #(
    .WIDTH(BITWIDTH + 1),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_data({a_last, a_data}),
    .pop      (fifo_pop),
    .pop_data (fifo_rd),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    preload_d = 1'b0;
    din0_d    = '0;
    din1_d    = '0;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE, W1: begin
        if (w_valid) begin
          preload_d        = 1'b1;
          {din1_d, din0_d} = w_data;
          state_d          = (state_q == IDLE) ? W1 : STREAM;
        end
      end
      STREAM: begin
        // An empty FIFO leaves a zero bubble on din0 rather than stalling the core.
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          din0_d   = pop_data;
          if (pop_last) begin
            cnt_d   = CW'(DRAIN_CYCLES - 1);
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      preload_q <= 1'b0;
      din0_q    <= '0;
      din1_q    <= '0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      preload_q <= preload_d;
      din0_q    <= din0_d;
      din1_q    <= din1_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
    end
  end

  assign preload_en = preload_q;
  assign din0       = din0_q;
  assign din1       = din1_q;
  assign done       = done_q;

  a_count_range: assert property (@(posedge clk) disable iff (reset) fifo_count <= DEPTH);

endmodule

// File: tb/tb_systolic_feeder_2x2.sv
// Directed bench for systolic_feeder_2x2 with weight/activation scoreboards and a drain model.
module tb_systolic_feeder_2x2;
  import systolic_pkg::*;

  localparam int BW    = 4;
  localparam int DRAIN = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          w_valid = 1'b0;
  logic [2*BW-1:0] w_data = '0;
  logic          a_valid = 1'b0;
  logic [BW-1:0] a_data = '0;
  logic          a_last = 1'b0;
  logic          w_ready, a_ready, preload_en, busy, done;
  logic [BW-1:0] din0, din1;

  systolic_feeder_2x2 dut (
    .clk       (clk),
    .reset     (reset),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_data    (a_data),
    .a_last    (a_last),
    .preload_en(preload_en),
    .din0      (din0),
    .din1      (din1),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int drain_cnt = 0;
  int wbeats = 0;
  bit toggle_mode = 1'b0;
  bit phase = 1'b0;

  logic [2*BW-1:0] exp_w[$];
  logic [BW:0]     exp_a[$];
  logic [BW:0]     a_src[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Present the head of the activation source, optionally every other cycle.
  task automatic drive_act();
    if (a_src.size() > 0 && (!toggle_mode || phase)) begin
      a_valid = 1'b1;
      {a_last, a_data} = a_src[0];
    end else begin
      a_valid = 1'b0;
      a_last  = 1'b0;
      a_data  = '0;
    end
    phase = ~phase;
  endtask

  task automatic check_outputs();
    logic [2*BW-1:0] ew;
    logic [BW:0]     ea;
    if (drain_cnt > 0) begin
      check("drain_preload", preload_en, 0);
      check("drain_din0", din0, 0);
      check("drain_din1", din1, 0);
      check("drain_done", done, (drain_cnt == 1));
      drain_cnt--;
      if (drain_cnt == 0) wbeats = 0;
    end else begin
      check("done_early", done, 0);
      if (preload_en) begin
        wbeats++;
        check("preload_beats", (wbeats <= 2), 1);
        check("w_q_nonempty", (exp_w.size() != 0), 1);
        if (exp_w.size() != 0) begin
          ew = exp_w.pop_front();
          check("w_row", {din1, din0}, ew);
        end
      end else begin
        check("din1_zero", din1, 0);
        if (din0 != '0) begin
          check("early_pop", (wbeats == 2), 1);
          check("a_q_nonempty", (exp_a.size() != 0), 1);
          if (exp_a.size() != 0) begin
            ea = exp_a.pop_front();
            check("act_data", din0, ea[BW-1:0]);
            if (ea[BW]) drain_cnt = DRAIN;
          end
        end
      end
    end
  endtask

  // Activations are queued as expected only after the same-edge output check, so a beat
  // showing up on din0 at its own acceptance edge is caught as unexpected.
  task automatic tick();
    logic        w_fire, a_fire;
    logic [BW:0] a_cur;
    w_fire = w_valid && w_ready && !reset;
    a_fire = a_valid && a_ready && !reset;
    a_cur  = {a_last, a_data};
    @(posedge clk);
    #1;
    if (w_fire) exp_w.push_back(w_data);
    if (a_fire) void'(a_src.pop_front());
    check_outputs();
    if (a_fire) exp_a.push_back(a_cur);
    drive_act();
  endtask

  task automatic send_w(input logic [2*BW-1:0] d);
    bit got;
    got = 1'b0;
    w_valid = 1'b1;
    w_data  = d;
    for (int i = 0; i < 20 && !got; i++) begin
      got = w_ready;
      tick();
    end
    w_valid = 1'b0;
    w_data  = '0;
    check("w_accept_timeout", got, 1);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) tick();
    check("idle_timeout", busy, 0);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_exp_w_left"}, exp_w.size(), 0);
    check({tag, "_exp_a_left"}, exp_a.size(), 0);
    check({tag, "_src_left"}, a_src.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_act();
    repeat (2) @(posedge clk);
    #1;
    check("rst_preload", preload_en, 0);
    check("rst_din0", din0, 0);
    check("rst_din1", din1, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_w_ready", w_ready, 1);
    check("rst_a_ready", a_ready, 1);
    reset = 1'b0;

    // 1: back-to-back weight rows
    send_w(8'h21);
    check("t1_preload0", preload_en, 1);
    check("t1_din0_row0", din0, 4'h1);
    check("t1_din1_row0", din1, 4'h2);
    send_w(8'h43);
    check("t1_preload1", preload_en, 1);
    check("t1_din0_row1", din0, 4'h3);
    check("t1_din1_row1", din1, 4'h4);
    check("t1_w_ready_low", w_ready, 0);
    check("t1_busy", busy, 1);

    // 2: activations 5,6,7(last) with a_valid held
    a_src = '{5'h05, 5'h06, 5'h17};
    drive_act();
    repeat (3) tick();
    check("t2_din0_6", din0, 4'h6);
    tick();
    check("t2_din0_7", din0, 4'h7);
    check("t2_din1", din1, 0);
    wait_idle(20);
    check("t2_done", done, 1);
    check_drained("t2");

    // 3: two idle cycles between weight beats, activations prefetched meanwhile
    a_src = '{5'h09, 5'h1A};
    drive_act();
    send_w(8'h65);
    tick();
    check("t3_gap_preload", preload_en, 0);
    check("t3_gap_din0", din0, 0);
    tick();
    check("t3_gap2_preload", preload_en, 0);
    check("t3_gap2_din", {din1, din0}, 0);
    check("t3_w_ready", w_ready, 1);
    send_w(8'h87);
    check("t3_row1", {din1, din0}, 8'h87);
    wait_idle(20);
    check("t3_done", done, 1);
    check_drained("t3");

    // 4: DEPTH+2 activations offered while idle
    a_src = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h16};
    drive_act();
    repeat (4) tick();
    check("t4_a_ready_full", a_ready, 0);
    check("t4_idle", busy, 0);
    repeat (2) tick();
    check("t4_src_held", a_src.size(), 2);
    check("t4_still_full", a_ready, 0);
    send_w(8'h21);
    send_w(8'h43);
    wait_idle(40);
    check("t4_done", done, 1);
    check_drained("t4");

    // 5: a_valid toggling every other cycle during STREAM
    send_w(8'h5A);
    send_w(8'hC3);
    toggle_mode = 1'b1;
    phase = 1'b1;
    a_src = '{5'h0B, 5'h0C, 5'h1D};
    drive_act();
    wait_idle(40);
    check("t5_done", done, 1);
    toggle_mode = 1'b0;
    check_drained("t5");

    // 6: reset mid-STREAM with two entries buffered
    a_src = '{5'h03, 5'h04, 5'h05};
    drive_act();
    send_w(8'h21);
    send_w(8'h43);
    tick();
    check("t6_first_act", din0, 4'h3);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_preload", preload_en, 0);
    check("t6_rst_din", {din1, din0}, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_a_ready", a_ready, 1);
    exp_w.delete();
    exp_a.delete();
    drain_cnt = 0;
    wbeats = 0;
    tick();
    reset = 1'b0;
    tick();
    check("t6_post_busy", busy, 0);
    a_src = '{5'h01, 5'h12};
    drive_act();
    send_w(8'h21);
    send_w(8'h43);
    wait_idle(20);
    check("t6_done", done, 1);
    check_drained("t6");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
